// File: rtl/axi4_mm_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi4_mm_read_responder
// Description : AXI4 read-only slave over an internal word array, one burst
//               in flight, FIXED/INCR/WRAP sequencing, backdoor preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_mm_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         bk_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] bk_addr,
    input  logic [DATA_WIDTH-1:0]        bk_wdata
);

    localparam int c_ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int c_IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;
    localparam logic [1:0] c_BURST_RSVD  = 2'b11;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  r_arready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_burst_err;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  r_rvalid;

    logic                  w_accept;
    logic                  w_advance;
    logic                  w_finish;
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_ar_err;
    logic                  w_oob;
    logic                  w_err;
    logic [c_IDX_W-1:0]    w_idx;
    logic [7:0]            w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic [1:0]            w_beat_resp;

    assign s_axi_arready = r_arready;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rvalid  = r_rvalid;

    assign w_accept  = r_arready & s_axi_arvalid;
    assign w_advance = r_rvalid & s_axi_rready & ~r_rlast;
    assign w_finish  = r_rvalid & s_axi_rready & r_rlast;
    assign w_cnt_nxt = r_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_BURST;
            c_ST_BURST: if (w_finish) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // WRAP lengths are restricted to 2/4/8/16 beats, so the wrap span is a
    // power of two and the boundary arithmetic reduces to masking.
    always_comb begin
        w_bytes     = ADDR_WIDTH'(1) << r_size;
        w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
        w_incr      = r_addr + w_bytes;
        case (r_burst)
            c_BURST_FIXED: w_next_addr = r_addr;
            c_BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:       w_next_addr = w_incr;
        endcase
    end

    always_comb begin
        w_ar_err = (s_axi_arsize > 3'(c_ADDR_LSB)) || (s_axi_arburst == c_BURST_RSVD) ||
                   ((s_axi_arburst == c_BURST_WRAP) &&
                    !((s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                      (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15)));
        w_beat_addr = (r_state == c_ST_IDLE) ? s_axi_araddr : w_next_addr;
        w_oob       = {1'b0, w_beat_addr} >= c_MEM_BYTES;
        w_err       = ((r_state == c_ST_IDLE) ? w_ar_err : r_burst_err) | w_oob;
        w_idx       = w_beat_addr[c_ADDR_LSB +: c_IDX_W];
        // Combinational read registered into rdata: a same-edge backdoor write
        // to this word is seen only by later beats.
        w_beat_data = w_err ? '0 : r_mem[w_idx];
        w_beat_resp = w_err ? c_RESP_SLVERR : c_RESP_OKAY;
    end

    always_ff @(posedge aclk) begin
        if (bk_we) r_mem[bk_addr] <= bk_wdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arready   <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_burst_err <= 1'b0;
            r_rid       <= '0;
            r_rdata     <= '0;
            r_rresp     <= c_RESP_OKAY;
            r_rlast     <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            r_arready <= (w_state_nxt == c_ST_IDLE);
            if (w_accept) begin
                r_addr      <= s_axi_araddr;
                r_len       <= s_axi_arlen;
                r_size      <= s_axi_arsize;
                r_burst     <= s_axi_arburst;
                r_cnt       <= '0;
                r_burst_err <= w_ar_err;
                r_rid       <= s_axi_arid;
                r_rdata     <= w_beat_data;
                r_rresp     <= w_beat_resp;
                r_rlast     <= (s_axi_arlen == 8'd0);
                r_rvalid    <= 1'b1;
            end else if (w_advance) begin
                r_addr  <= w_next_addr;
                r_cnt   <= w_cnt_nxt;
                r_rdata <= w_beat_data;
                r_rresp <= w_beat_resp;
                r_rlast <= (w_cnt_nxt == r_len);
            end else if (w_finish) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_mm_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_mm_read_responder
// Description : Scoreboard bench for the AXI4 read responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_mm_read_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bk_we;
    logic [9:0]  bk_addr;
    logic [31:0] bk_wdata;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi4_mm_read_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata)
    );

    task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        beat_t b;
        b.data = d; b.resp = r; b.last = l; b.id = id;
        sb.push_back(b);
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu);
        int w = 0;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        while (!arready && w < 20) begin
            @(posedge aclk); #1; w++;
        end
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL ar_accept: arready=%b required 1 within 20 cycles", arready);
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    // Called in the cycle after the AR handshake; expects beats every cycle.
    task automatic collect(input int n, input int stall_at, input int stall_len, input bit check_end);
        int got = 0, cyc = 0, stalled = 0;
        beat_t e;
        logic [38:0] held;
        while (got < n && cyc < 100) begin
            checks++;
            if (rvalid !== 1'b1) begin
                failures++;
                $display("FAIL rvalid_gap: beat %0d rvalid=%b required 1", got, rvalid);
            end
            checks++;
            if (arready !== 1'b0) begin
                failures++;
                $display("FAIL arready_in_burst: arready=%b required 0", arready);
            end
            if (got == stall_at && stalled < stall_len) begin
                if (stalled == 0) begin
                    held = {rdata, rresp, rlast, rid};
                end else begin
                    checks++;
                    if ({rdata, rresp, rlast, rid} !== held) begin
                        failures++;
                        $display("FAIL hold_stable: {rdata,rresp,rlast,rid}=%h required %h",
                                 {rdata, rresp, rlast, rid}, held);
                    end
                end
                rready = 1'b0;
                stalled++;
            end else begin
                rready = 1'b1;
                if (rvalid === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_empty: unexpected beat rdata=%h required none", rdata);
                    end else begin
                        e = sb.pop_front();
                        if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
                            failures++;
                            $display("FAIL beat%0d: rdata=%h rresp=%b rlast=%b rid=%h required rdata=%h rresp=%b rlast=%b rid=%h",
                                     got, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                        end
                    end
                    got++;
                end
            end
            @(posedge aclk); #1; cyc++;
        end
        rready = 1'b1;
        checks++;
        if (got < n) begin
            failures++;
            $display("FAIL beat_timeout: got %0d beats required %0d", got, n);
        end
        if (check_end) begin
            checks++;
            if (rvalid !== 1'b0 || arready !== 1'b1) begin
                failures++;
                $display("FAIL turnaround: rvalid=%b arready=%b required 0 1", rvalid, arready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({arready, rvalid, rlast, rid, rdata, rresp} !== 40'd0) begin
            failures++;
            $display("FAIL reset_values: arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b required all 0",
                     arready, rvalid, rlast, rid, rdata, rresp);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL reset_exit: arready=%b required 1", arready);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 1024; i++) begin
            bk_we = 1'b1; bk_addr = 10'(i); bk_wdata = i;
            @(posedge aclk); #1;
        end
        bk_we = 1'b0;
    endtask

    task automatic test_incr();
        issue_ar(4'h1, 32'h10, 8'd3, 3'd2, 2'b01);
        push(32'd4, 2'b00, 1'b0, 4'h1);
        push(32'd5, 2'b00, 1'b0, 4'h1);
        push(32'd6, 2'b00, 1'b0, 4'h1);
        push(32'd7, 2'b00, 1'b1, 4'h1);
        collect(4, -1, 0, 1'b1);
        issue_ar(4'h6, 32'h0C, 8'd0, 3'd2, 2'b01);
        push(32'd3, 2'b00, 1'b1, 4'h6);
        collect(1, -1, 0, 1'b1);
    endtask

    task automatic test_wrap();
        issue_ar(4'h2, 32'h38, 8'd3, 3'd2, 2'b10);
        push(32'd14, 2'b00, 1'b0, 4'h2);
        push(32'd15, 2'b00, 1'b0, 4'h2);
        push(32'd12, 2'b00, 1'b0, 4'h2);
        push(32'd13, 2'b00, 1'b1, 4'h2);
        collect(4, -1, 0, 1'b1);
    endtask

    task automatic test_fixed_backpressure();
        issue_ar(4'h3, 32'h20, 8'd2, 3'd2, 2'b00);
        push(32'd8, 2'b00, 1'b0, 4'h3);
        push(32'd8, 2'b00, 1'b0, 4'h3);
        push(32'd8, 2'b00, 1'b1, 4'h3);
        collect(3, 1, 3, 1'b1);
        issue_ar(4'h3, 32'h24, 8'd1, 3'd2, 2'b01);
        push(32'd9, 2'b00, 1'b0, 4'h3);
        push(32'd10, 2'b00, 1'b1, 4'h3);
        collect(2, 1, 3, 1'b1);
    endtask

    task automatic test_out_of_range();
        issue_ar(4'h4, 32'hFF8, 8'd3, 3'd2, 2'b01);
        push(32'd1022, 2'b00, 1'b0, 4'h4);
        push(32'd1023, 2'b00, 1'b0, 4'h4);
        push(32'd0, 2'b10, 1'b0, 4'h4);
        push(32'd0, 2'b10, 1'b1, 4'h4);
        collect(4, -1, 0, 1'b1);
    endtask

    task automatic test_burst_errors();
        issue_ar(4'h5, 32'h0, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) push(32'd0, 2'b10, (i == 3), 4'h5);
        collect(4, -1, 0, 1'b1);
        issue_ar(4'h7, 32'h0, 8'd1, 3'd2, 2'b11);
        for (int i = 0; i < 2; i++) push(32'd0, 2'b10, (i == 1), 4'h7);
        collect(2, -1, 0, 1'b1);
        issue_ar(4'h8, 32'h10, 8'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) push(32'd0, 2'b10, (i == 2), 4'h8);
        collect(3, -1, 0, 1'b1);
    endtask

    task automatic test_reset_midburst();
        issue_ar(4'h5, 32'h0, 8'd15, 3'd2, 2'b01);
        push(32'd0, 2'b00, 1'b0, 4'h5);
        push(32'd1, 2'b00, 1'b0, 4'h5);
        collect(2, -1, 0, 1'b0);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'd2) begin
            failures++;
            $display("FAIL beat2_present: rvalid=%b rdata=%h required 1 00000002", rvalid, rdata);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: rvalid=%b arready=%b required 0 0", rvalid, arready);
        end
        sb.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        issue_ar(4'h9, 32'h40, 8'd1, 3'd2, 2'b01);
        push(32'd16, 2'b00, 1'b0, 4'h9);
        push(32'd17, 2'b00, 1'b1, 4'h9);
        collect(2, -1, 0, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; rready = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_wdata = '0;
        test_reset();
        preload();
        test_incr();
        test_wrap();
        test_fixed_backpressure();
        test_out_of_range();
        test_burst_errors();
        test_reset_midburst();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d beats outstanding required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
